// File: rtl/dmem_lsu_pkg.sv
// Shared constants, state encoding and address/funct3 helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

   localparam int NUM_LANES = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_ERR} state_t;

   // Load-side context kept from acceptance until the read word returns.
   typedef struct packed {
      logic [2:0] funct3;
      logic [1:0] lo;
   } ld_ctl_t;

   function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    return 4'b0001 << a;
         SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
      if (write) return f3 >= 3'b011;
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Natural alignment of the byte offset for the access size.
   function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    return a;
         SZ_H:    return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return align_lo(size, a) != a;
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational datapath: store byte enables and lane replication, load lane select and extension.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_lanes,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_lo,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [NUM_LANES-1:0][7:0] src, dst, rd;
   logic [7:0]  b;
   logic [15:0] h;

   assign src      = st_data;
   assign st_be    = be_for(st_size, st_lo);
   assign st_lanes = dst;

   // Byte stores feed lane 0 everywhere, halfword stores repeat the low half.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign dst[i] = (st_size == SZ_B) ? src[0] :
                      (st_size == SZ_H) ? src[i % 2] : src[i];
   end

   assign rd = ld_word;
   assign b  = rd[ld_lo];
   assign h  = ld_lo[1] ? {rd[3], rd[2]} : {rd[1], rd[0]};

   always_comb begin
      ld_data = ld_word;
      case (ld_funct3)
         F3_LB:   ld_data = {{24{b[7]}}, b};
         F3_LBU:  ld_data = {24'b0, b};
         F3_LH:   ld_data = {{16{h[15]}}, h};
         F3_LHU:  ld_data = {16'b0, h};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: request FSM and registered SRAM/response interface.
// Define DMEM_LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready
);

   state_t      state;
   ld_ctl_t     ld_ctl;
   logic [1:0]  req_size, req_lo;
   logic        req_bad;
   logic [3:0]  st_be;
   logic [31:0] st_lanes, ld_data;
   logic        unused_addr;

   assign req_size    = req_funct3[1:0];
   assign req_lo      = align_lo(req_size, req_addr[1:0]);
   assign unused_addr = ^req_addr[31:MEM_AW+2];

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   assign req_bad = f3_illegal(req_write, req_funct3) | misaligned(req_size, req_addr[1:0]);
`else
   assign req_bad = f3_illegal(req_write, req_funct3);
`endif

   dmem_lsu_align u_align (
      .st_size   (req_size),
      .st_lo     (req_lo),
      .st_data   (req_wdata),
      .st_be     (st_be),
      .st_lanes  (st_lanes),
      .ld_funct3 (ld_ctl.funct3),
      .ld_lo     (ld_ctl.lo),
      .ld_word   (mem_rdata),
      .ld_data   (ld_data)
   );

   // Memory-side outputs are loaded at acceptance and held until mem_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ld_ctl     <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  ld_ctl    <= '{funct3: req_funct3, lo: req_lo};
                  if (req_bad) begin
                     state      <= ST_ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state     <= ST_ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= req_write;
                     mem_be    <= st_be;
                     mem_addr  <= req_addr[MEM_AW+1:2];
                     mem_wdata <= st_lanes;
                  end
               end
            end
            ST_ACCESS: begin
               if (mem_ready) begin
                  state      <= ST_RESP;
                  mem_en     <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= mem_we ? '0 : ld_data;
               end
            end
            ST_RESP, ST_ERR: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural variable-latency SRAM and a response scoreboard.
module tb_dmem_lsu;

   localparam int MEM_AW = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_write;
   logic [31:0]       req_addr, req_wdata;
   logic [2:0]        req_funct3;
   logic              resp_valid, resp_err;
   logic [31:0]       resp_rdata;
   logic              mem_en, mem_we, mem_ready;
   logic [3:0]        mem_be;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;

   dmem_lsu #(.MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // SRAM model: mem_ready rises in the ready_on-th cycle of an access.
   logic [31:0] mem [0:(1<<MEM_AW)-1];
   int wait_cnt = 0;
   int ready_on = 1;

   assign mem_ready = mem_en && (wait_cnt + 1 >= ready_on);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_en && !mem_ready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (mem_en && mem_ready && mem_we)
         for (int i = 0; i < 4; i++)
            if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
   end

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   int compared = 0;
   int mismatched = 0;

   int              lat, en_cnt;
   bit              stable, busy_ok;
   logic            c_we;
   logic [3:0]      c_be;
   logic [MEM_AW-1:0] c_addr;
   logic [31:0]     c_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
      exp_t e;
      e.err = exp_err;
      e.rdata = exp_rd;
      sb.push_back(e);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; en_cnt = 0; stable = 1'b1; busy_ok = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) begin
            c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wdata = mem_wdata;
         end
         if (mem_en) begin
            en_cnt++;
            if ({mem_we, mem_be, mem_addr, mem_wdata} !== {c_we, c_be, c_addr, c_wdata}) stable = 1'b0;
         end
         if (req_ready) busy_ok = 1'b0;
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
      chk("resp_seen", {31'b0, lat != 0}, 1);
      e = sb.pop_front();
      chk("resp_err", resp_err, e.err);
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("busy_not_ready", busy_ok, 1);
   endtask

   bit seen;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_funct3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_resp_rdata", resp_rdata, 0);

      run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      chk("sw_be", c_be, 4'b1111);
      chk("sw_addr", c_addr, 4);
      chk("sw_wdata", c_wdata, 32'hDEADBEEF);
      chk("sw_we", c_we, 1);
      chk("sw_lat", lat, 2);

      run(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
      chk("lw_we", c_we, 0);
      chk("lw_lat", lat, 2);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      run(1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0);
      chk("mis_lat", lat, 1);
      chk("mis_no_en", en_cnt, 0);
      run(1'b0, 3'b001, 32'h13, 32'h0, 1'b1, 32'h0);
      chk("mis_h_no_en", en_cnt, 0);
`else
      run(1'b0, 3'b010, 32'h11, 32'h0, 1'b0, 32'hDEADBEEF);
      chk("mis_addr", c_addr, 4);
      chk("mis_lat", lat, 2);
`endif

      run(1'b1, 3'b000, 32'h13, 32'h12345680, 1'b0, 32'h0);
      chk("sb_be", c_be, 4'b1000);
      chk("sb_wdata", c_wdata, 32'h80808080);
      run(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
      run(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080);

      run(1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0, 32'h0);
      chk("sh_be", c_be, 4'b1100);
      chk("sh_wdata", c_wdata, 32'h80018001);
      chk("sh_addr", c_addr, 8);
      run(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF8001);
      run(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h00008001);

      // Upper address bits beyond the SRAM range wrap onto word 4.
      run(1'b0, 3'b010, 32'h1010, 32'h0, 1'b0, 32'h80ADBEEF);
      chk("wrap_addr", c_addr, 4);

      ready_on = 3;
      run(1'b1, 3'b010, 32'h40, 32'h11223344, 1'b0, 32'h0);
      chk("slow_lat", lat, 4);
      chk("slow_en_cycles", en_cnt, 3);
      chk("slow_stable", stable, 1);
      run(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h11223344);
      chk("slow_ld_lat", lat, 4);
      ready_on = 1;

      run(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
      chk("ill_ld_lat", lat, 1);
      chk("ill_ld_no_en", en_cnt, 0);
      run(1'b1, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
      chk("ill_st_no_en", en_cnt, 0);

      // Reset while an access is outstanding.
      ready_on = 6;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mid_en_before", mem_en, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_mem_en", mem_en, 0);
      chk("mid_resp_valid", resp_valid, 0);
      chk("mid_mem_be", mem_be, 0);
      chk("mid_mem_addr", mem_addr, 0);
      chk("mid_req_ready", req_ready, 1);
      rst_n = 1'b1;
      ready_on = 1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid || mem_en) seen = 1'b1;
      end
      chk("mid_no_resp", seen, 0);
      run(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the CPU memory stage and a word-organised data SRAM. It accepts one byte, halfword or word access per request, derives byte enables and lane-steered write data, waits on a variable-latency memory `mem_ready`, and returns sign- or zero-extended load data. It is the consumer of the core's `dmem_addr`/`dmem_write_data`/`dmem_funct3` and the producer of the `dmem_read_data`/`dmem_ready` path.

## Interface
- `MEM_AW`, 10: word-address width of the SRAM (default 1024 words = 4 KiB)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  1  CPU request present
- `req_ready`  out  1  unit can accept (high only in IDLE)
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `req_funct3`  in  3  RISC-V load/store funct3
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data (0 for stores/errors)
- `resp_err`  out  1  access rejected (valid with `resp_valid`)
- `mem_en`  out  1  SRAM access strobe
- `mem_we`  out  1  SRAM write
- `mem_be`  out  4  byte enables
- `mem_addr`  out  MEM_AW  word address = `req_addr[MEM_AW+1:2]`; upper bits ignored (wrap)
- `mem_wdata`  out  32  lane-steered write data
- `mem_rdata`  in  32  SRAM read word, valid when `mem_ready`
- `mem_ready`  in  1  SRAM completes current access

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: `req_ready`=1. On `req_valid`: latch request; illegal funct3 (load 011/110/111, store ≥011) or (with macro) misalignment -> ERR; else -> ACCESS.
- ACCESS: `mem_en`=1, `mem_we`/`mem_be`/`mem_addr`/`mem_wdata` held stable from latched request until `mem_ready`. On `mem_ready`: capture `mem_rdata` (loads) -> RESP.
- RESP: `resp_valid`=1, `resp_err`=0, `resp_rdata` = extended load or 0 for store -> IDLE.
- ERR: `resp_valid`=1, `resp_err`=1, `resp_rdata`=0, no memory access -> IDLE.
- Byte enables: SB `1<<a[1:0]`; SH `a[1]?1100:0011`; SW `1111`. Store data replicated: byte to all four lanes, halfword to both halves.
- Loads select lane by `a[1:0]` (byte) or `a[1]` (half); LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- `mem_ready` outside ACCESS is ignored.

## Timing
- Reset: state IDLE; `req_ready`=1 from first cycle after reset release; `resp_valid`, `resp_err`, `mem_en`, `mem_we`=0; `mem_be`, `mem_addr`, `mem_wdata`, `resp_rdata`=0.
- Accept at edge N -> `mem_en` high cycle N+1; `mem_ready` in cycle N+k -> `resp_valid` in cycle N+k+1. Zero-wait SRAM: 2-cycle latency, 1 request per 3 cycles.
- Error path: `resp_valid` in cycle N+1.
- `req_valid` while `req_ready`=0 is not accepted; CPU must hold request.
- Reset asserted mid-access: access abandoned, no `resp_valid`, `mem_en` low the next cycle.
- Back-to-back: new request accepted in the cycle `resp_valid` deasserts (return to IDLE).

## Configuration
- `DMEM_LSU_MISALIGN_TRAP_EN` defined: halfword with `a[0]`=1 or word with `a[1:0]`≠0 -> ERR path, no SRAM access.
- Undefined: low address bits forced to natural alignment (half: `a[0]`=0; word: `a[1:0]`=0) and access proceeds; `resp_err` only for illegal funct3.

## Structure
- `dmem_lsu_pkg`: funct3 constants (LB..LHU, SB/SH/SW), state enum, `be_for()` helper.
- Sub-module `dmem_lsu_align`: combinational byte-enable generation, store replication, load lane select and extension; FSM and registers stay in `dmem_lsu`.

## Test plan
- SW 0xDEADBEEF @0x10, zero-wait SRAM -> `mem_be`=1111, `mem_addr`=4, resp at +2 cycles; LW @0x10 -> `resp_rdata`=0xDEADBEEF.
- SB 0x80 @0x13 -> `mem_be`=1000, `mem_wdata`=0x80808080; LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0x8001 @0x22, then LH -> 0xFFFF8001, LHU -> 0x00008001, `mem_be`=1100.
- SRAM with 3-cycle `mem_ready` delay -> signals held stable 3 cycles, `req_ready`=0 throughout, resp at +4.
- LW @0x11: with macro -> `resp_err`=1 at +1, no `mem_en`; without -> reads word 4.
- Load funct3=011 -> `resp_err`=1, `resp_rdata`=0; `rst_n` low during ACCESS -> no `resp_valid`, outputs at reset values.
